// File: rtl/polar_sched_pkg.sv
// polar_sched_pkg: shared tag/result types and constants for the CORDIC scheduler
package polar_sched_pkg;
  localparam int PHASE_W = 32;
  localparam int WIDTH_D = 32;
  localparam int IDXW_D = 10;
  typedef struct packed {
    logic              ch;
    logic [IDXW_D-1:0] idx;
    logic              last;
    logic              vld;
  } tag_t;
  typedef struct packed {
    logic [WIDTH_D-1:0] mag;
    logic [PHASE_W-1:0] phase;
    logic [IDXW_D-1:0]  idx;
    logic               last;
  } res_t;
endpackage

// File: rtl/polar_out_fifo.sv
// polar_out_fifo: synchronous FIFO with registered first-word fall-through head and occupancy count
module polar_out_fifo
  import polar_sched_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  res_t        i_din,
  input  logic        i_pop,
  output res_t        o_dout,
  output logic        o_vld,
  output logic [AW:0] o_count
);
  res_t          r_mem [DEPTH];
  res_t          r_head;
  logic [AW-1:0] r_wp, r_rp, w_rp_n;
  logic [AW:0]   r_cnt, w_left;
  logic          w_pop;
  always_comb begin
    w_pop  = i_pop && r_cnt != '0;
    w_rp_n = r_rp + AW'(w_pop);
    w_left = r_cnt - (AW+1)'(w_pop);
  end
  always_ff @(posedge clk) if (i_push) r_mem[r_wp] <= i_din;
  // The head register is refreshed with whatever will be at the read pointer next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_head <= '0;
    end else begin
      r_wp   <= r_wp + AW'(i_push);
      r_rp   <= w_rp_n;
      r_cnt  <= w_left + (AW+1)'(i_push);
      r_head <= w_left != '0 ? r_mem[w_rp_n] : i_push ? i_din : r_head;
    end
  end
  assign o_dout  = r_head;
  assign o_vld   = r_cnt != '0;
  assign o_count = r_cnt;
endmodule

// File: rtl/polar_sched.sv
// polar_sched: round-robin two-channel scheduler around an external pipelined CORDIC
// with a latency-matched tag line and credit-guarded per-channel output FIFOs.
module polar_sched
  import polar_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int LAT = 17,
  parameter int FIFO_DEPTH = 32,
  parameter int IDXW = IDXW_D,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s0_vld,
  output logic                    s0_rdy,
  input  logic signed [WIDTH-1:0] s0_x,
  input  logic signed [WIDTH-1:0] s0_y,
  input  logic [IDXW-1:0]         s0_idx,
  input  logic                    s0_last,
  input  logic                    s1_vld,
  output logic                    s1_rdy,
  input  logic signed [WIDTH-1:0] s1_x,
  input  logic signed [WIDTH-1:0] s1_y,
  input  logic [IDXW-1:0]         s1_idx,
  input  logic                    s1_last,
  output logic                    cv_vld,
  output logic signed [WIDTH-1:0] cv_x,
  output logic signed [WIDTH-1:0] cv_y,
  input  logic                    cv_o_vld,
  input  logic [WIDTH-1:0]        cv_mag,
  input  logic [PHASE_W-1:0]      cv_phase,
  output logic                    m0_vld,
  input  logic                    m0_rdy,
  output logic [WIDTH-1:0]        m0_mag,
  output logic [PHASE_W-1:0]      m0_phase,
  output logic [IDXW-1:0]         m0_idx,
  output logic                    m0_last,
  output logic                    m1_vld,
  input  logic                    m1_rdy,
  output logic [WIDTH-1:0]        m1_mag,
  output logic [PHASE_W-1:0]      m1_phase,
  output logic [IDXW-1:0]         m1_idx,
  output logic                    m1_last,
  output logic                    busy,
  output logic                    err_sync
);
  tag_t                    r_tag [LAT+1];
  logic [CW-1:0]           r_inf [2];
  logic [CW-1:0]           w_cnt [2];
  logic                    r_last, r_err, r_cv_vld;
  logic signed [WIDTH-1:0] r_cv_x, r_cv_y;
  logic [1:0]              w_elig, w_gnt, w_dec, w_push;
  tag_t                    w_tag_new, w_tail;
  res_t                    w_res, w_q0, w_q1;
  always_comb begin
    w_elig[0] = !rst && s0_vld && (CW+1)'(w_cnt[0]) + (CW+1)'(r_inf[0]) < (CW+1)'(FIFO_DEPTH);
    w_elig[1] = !rst && s1_vld && (CW+1)'(w_cnt[1]) + (CW+1)'(r_inf[1]) < (CW+1)'(FIFO_DEPTH);
    w_gnt[0]  = w_elig[0] && (!w_elig[1] || r_last);
    w_gnt[1]  = w_elig[1] && (!w_elig[0] || !r_last);
    w_tag_new = '{ch: w_gnt[1], idx: w_gnt[1] ? s1_idx : s0_idx,
                  last: w_gnt[1] ? s1_last : s0_last, vld: |w_gnt};
    w_tail    = r_tag[LAT];
    w_dec[0]  = w_tail.vld && !w_tail.ch;
    w_dec[1]  = w_tail.vld && w_tail.ch;
    w_push    = w_dec & {2{cv_o_vld}};
    w_res     = '{mag: cv_mag, phase: cv_phase, idx: w_tail.idx, last: w_tail.last};
  end
  // Stage 0 rides alongside cv_vld, so stage LAT lines up with cv_o_vld.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cv_vld <= 1'b0;
      r_cv_x   <= '0;
      r_cv_y   <= '0;
      r_tag    <= '{default: '0};
      r_inf    <= '{default: '0};
      r_last   <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      r_cv_vld <= |w_gnt;
      if (|w_gnt) begin
        r_cv_x <= w_gnt[1] ? s1_x : s0_x;
        r_cv_y <= w_gnt[1] ? s1_y : s0_y;
        r_last <= w_gnt[1];
      end
      r_tag[0] <= w_tag_new;
      for (int i = 1; i <= LAT; i++) r_tag[i] <= r_tag[i-1];
      r_inf[0] <= r_inf[0] + CW'(w_gnt[0]) - CW'(w_dec[0]);
      r_inf[1] <= r_inf[1] + CW'(w_gnt[1]) - CW'(w_dec[1]);
      if (w_tail.vld != cv_o_vld) r_err <= 1'b1;
    end
  end
  polar_out_fifo #(.DEPTH(FIFO_DEPTH)) u_f0 (
    .clk(clk), .rst(rst), .i_push(w_push[0]), .i_din(w_res), .i_pop(m0_rdy),
    .o_dout(w_q0), .o_vld(m0_vld), .o_count(w_cnt[0])
  );
  polar_out_fifo #(.DEPTH(FIFO_DEPTH)) u_f1 (
    .clk(clk), .rst(rst), .i_push(w_push[1]), .i_din(w_res), .i_pop(m1_rdy),
    .o_dout(w_q1), .o_vld(m1_vld), .o_count(w_cnt[1])
  );
  assign s0_rdy   = w_gnt[0];
  assign s1_rdy   = w_gnt[1];
  assign cv_vld   = r_cv_vld;
  assign cv_x     = r_cv_x;
  assign cv_y     = r_cv_y;
  assign m0_mag   = w_q0.mag;
  assign m0_phase = w_q0.phase;
  assign m0_idx   = w_q0.idx;
  assign m0_last  = w_q0.last;
  assign m1_mag   = w_q1.mag;
  assign m1_phase = w_q1.phase;
  assign m1_idx   = w_q1.idx;
  assign m1_last  = w_q1.last;
  assign busy     = |{r_inf[0], r_inf[1], w_cnt[0], w_cnt[1]};
  assign err_sync = r_err;
endmodule

// File: tb/tb_polar_sched.sv
// tb_polar_sched: directed checks of arbitration, latency, credit, retire/pop, error flag and reset
module tb_polar_sched;
  localparam int WIDTH = 32, LAT = 17, DEPTH = 4, IDXW = 10;
  logic clk = 0, rst = 1;
  logic s0_vld = 0, s1_vld = 0, s0_last = 0, s1_last = 0;
  logic s0_rdy, s1_rdy;
  logic signed [WIDTH-1:0] s0_x = 0, s0_y = 0, s1_x = 0, s1_y = 0;
  logic [IDXW-1:0] s0_idx = 0, s1_idx = 0;
  logic cv_vld, cv_o_vld, inj = 0;
  logic signed [WIDTH-1:0] cv_x, cv_y;
  logic [WIDTH-1:0] cv_mag;
  logic [31:0] cv_phase;
  logic m0_vld, m1_vld, m0_rdy = 1, m1_rdy = 1, m0_last, m1_last, busy, err_sync;
  logic [WIDTH-1:0] m0_mag, m1_mag;
  logic [31:0] m0_phase, m1_phase;
  logic [IDXW-1:0] m0_idx, m1_idx;
  logic cp_v [LAT];
  logic [WIDTH-1:0] cp_x [LAT], cp_y [LAT];
  int n_cmp = 0, n_bad = 0;
  int i0, i1, c0, c1, hs, first;
  logic seen;

  always #5 clk = ~clk;

  // Stand-in converter: LAT-cycle pipe returning mag=x, phase=y, cleared by rst.
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < LAT; i++) cp_v[i] <= 1'b0;
    else begin
      cp_v[0] <= cv_vld;
      cp_x[0] <= cv_x;
      cp_y[0] <= cv_y;
      for (int i = 1; i < LAT; i++) begin
        cp_v[i] <= cp_v[i-1];
        cp_x[i] <= cp_x[i-1];
        cp_y[i] <= cp_y[i-1];
      end
    end
  end
  assign cv_o_vld = cp_v[LAT-1] | inj;
  assign cv_mag   = cp_x[LAT-1];
  assign cv_phase = cp_y[LAT-1];

  polar_sched #(.WIDTH(WIDTH), .LAT(LAT), .FIFO_DEPTH(DEPTH), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst),
    .s0_vld(s0_vld), .s0_rdy(s0_rdy), .s0_x(s0_x), .s0_y(s0_y), .s0_idx(s0_idx), .s0_last(s0_last),
    .s1_vld(s1_vld), .s1_rdy(s1_rdy), .s1_x(s1_x), .s1_y(s1_y), .s1_idx(s1_idx), .s1_last(s1_last),
    .cv_vld(cv_vld), .cv_x(cv_x), .cv_y(cv_y), .cv_o_vld(cv_o_vld), .cv_mag(cv_mag), .cv_phase(cv_phase),
    .m0_vld(m0_vld), .m0_rdy(m0_rdy), .m0_mag(m0_mag), .m0_phase(m0_phase), .m0_idx(m0_idx), .m0_last(m0_last),
    .m1_vld(m1_vld), .m1_rdy(m1_rdy), .m1_mag(m1_mag), .m1_phase(m1_phase), .m1_idx(m1_idx), .m1_last(m1_last),
    .busy(busy), .err_sync(err_sync)
  );

  always @(posedge clk) begin
    if (!rst && dut.u_f0.i_push && dut.u_f0.o_count == 3'(DEPTH) && !dut.u_f0.i_pop) begin
      n_bad++;
      $error("FAIL overflow_f0: push into full FIFO (count %0d, required < %0d)", dut.u_f0.o_count, DEPTH);
    end
    if (!rst && dut.u_f1.i_push && dut.u_f1.o_count == 3'(DEPTH) && !dut.u_f1.i_pop) begin
      n_bad++;
      $error("FAIL overflow_f1: push into full FIFO (count %0d, required < %0d)", dut.u_f1.o_count, DEPTH);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; s0_vld = 0; s1_vld = 0; m0_rdy = 1; m1_rdy = 1; inj = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    // reset values, with requests pending during rst
    s0_vld = 1; s1_vld = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_s0_rdy", s0_rdy, 0);
    chk("rst_s1_rdy", s1_rdy, 0);
    s0_vld = 0; s1_vld = 0; rst = 0;
    #1;
    chk("rst_cv_vld", cv_vld, 0);
    chk("rst_cv_x", cv_x, 0);
    chk("rst_cv_y", cv_y, 0);
    chk("rst_m0_vld", m0_vld, 0);
    chk("rst_m1_vld", m1_vld, 0);
    chk("rst_m0_mag", m0_mag, 0);
    chk("rst_m0_phase", m0_phase, 0);
    chk("rst_m0_idx", m0_idx, 0);
    chk("rst_m0_last", m0_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_sync, 0);

    // single sample latency
    @(negedge clk);
    s0_vld = 1; s0_x = 1000; s0_y = 0; s0_idx = 5; s0_last = 1;
    #1;
    chk("t1_hs", s0_rdy, 1);
    first = -1; seen = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      s0_vld = 0; s0_last = 0;
      #1;
      if (n == 1) begin
        chk("t1_cv_vld", cv_vld, 1);
        chk("t1_cv_x", cv_x, 1000);
      end
      if (m1_vld) seen = 1;
      if (m0_vld && first < 0) begin
        first = n;
        chk("t1_idx", m0_idx, 5);
        chk("t1_mag", m0_mag, 1000);
        chk("t1_phase", m0_phase, 0);
        chk("t1_last", m0_last, 1);
      end
    end
    chk("t1_latency", first, 19);
    chk("t1_m1_never", seen, 0);

    // two saturating channels alternate
    do_reset();
    i0 = 0; i1 = 0;
    for (int k = 0; k < 8; k++) begin
      s0_vld = 1; s1_vld = 1; s0_idx = 10'(10 + i0); s1_idx = 10'(20 + i1);
      s0_x = 100; s1_x = 200;
      #1;
      chk("t2_g0", s0_rdy, (k % 2) == 0);
      chk("t2_g1", s1_rdy, (k % 2) == 1);
      if (s0_rdy) i0++;
      if (s1_rdy) i1++;
      @(negedge clk);
    end
    s0_vld = 0; s1_vld = 0;
    c0 = 0; c1 = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (m0_vld) begin chk("t2_idx0", m0_idx, 10 + c0); chk("t2_mag0", m0_mag, 100); c0++; end
      if (m1_vld) begin chk("t2_idx1", m1_idx, 20 + c1); chk("t2_mag1", m1_mag, 200); c1++; end
    end
    chk("t2_cnt0", c0, 4);
    chk("t2_cnt1", c1, 4);

    // credit exhaustion with ch0 blocked downstream
    do_reset();
    i0 = 0; i1 = 0; hs = 0; m0_rdy = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      s0_vld = 1; s0_idx = 10'(i0);
      #1;
      if (s0_rdy) begin hs++; i0++; end
    end
    chk("t3_hs", hs, 4);
    @(negedge clk);
    s1_vld = 1; s1_idx = 10'(7);
    #1;
    chk("t3_s0_blocked", s0_rdy, 0);
    chk("t3_s1_granted", s1_rdy, 1);
    chk("t3_m0_vld", m0_vld, 1);
    @(negedge clk);
    s1_vld = 0; m0_rdy = 1;
    #1;
    chk("t3_s0_still_blocked", s0_rdy, 0);
    chk("t3_pop_idx", m0_idx, 0);
    hs = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      m0_rdy = 0; s0_vld = 1; s0_idx = 10'(i0);
      #1;
      if (s0_rdy) begin hs++; i0++; end
    end
    chk("t3_one_more", hs, 1);

    // retire and pop in the same cycle at the credit limit
    @(negedge clk);
    s0_vld = 0; m0_rdy = 1;
    #1;
    chk("t4_pop1", m0_idx, 1);
    @(negedge clk);
    m0_rdy = 0; s0_vld = 1; s0_idx = 10'(i0);
    #1;
    chk("t4_hs", s0_rdy, 1);
    for (int n = 1; n <= 19; n++) begin
      @(negedge clk);
      s0_vld = 0; m0_rdy = (n == 18);
      #1;
      if (n == 18) begin chk("t4_vld18", m0_vld, 1); chk("t4_pop2", m0_idx, 2); end
      if (n == 19) begin chk("t4_vld19", m0_vld, 1); chk("t4_head3", m0_idx, 3); end
    end
    c0 = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      m0_rdy = 1;
      #1;
      if (m0_vld) begin chk("t4_drain", m0_idx, 3 + c0); c0++; end
    end
    chk("t4_drain_cnt", c0, 3);

    // spurious converter valid on an empty tag pipe
    first = -1;
    for (int n = 0; n < 100 && first < 0; n++) begin
      @(negedge clk);
      if (!busy) first = n;
    end
    chk("t5_idle", first >= 0, 1);
    @(negedge clk);
    inj = 1;
    @(negedge clk);
    inj = 0;
    #1;
    chk("t5_err", err_sync, 1);
    chk("t5_no_m0", m0_vld, 0);
    chk("t5_no_m1", m1_vld, 0);
    chk("t5_busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("t5_sticky", err_sync, 1);
    do_reset();
    #1;
    chk("t5_rst_clr", err_sync, 0);

    // reset with samples in flight
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      s0_vld = 1; s1_vld = 1;
    end
    @(negedge clk);
    rst = 1;
    #1;
    chk("t6_rdy_in_rst", s0_rdy, 0);
    @(negedge clk);
    rst = 0; s0_vld = 0; s1_vld = 0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_m0", m0_vld, 0);
    chk("t6_m1", m1_vld, 0);
    seen = 0;
    for (int n = 0; n < 2 * LAT; n++) begin
      @(negedge clk);
      if (m0_vld || m1_vld) seen = 1;
    end
    chk("t6_no_stale", seen, 0);
    chk("t6_err", err_sync, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
